point_add_sched: RTL and testbench
==================================

// Module: point_add_sched
// PURPOSE
//  Round-robin scheduler that shares one point_add unit among NUM_REQ requesters (MSM bucket lanes).
//  Accepts one {P,Q} job at a time and drives the point_add Reset/Done sequence.
//  Returns R to the owning requester with a one-cycle response pulse.
//  A watchdog flags any job whose Done does not arrive within TIMEOUT cycles.
// PARAMETERS
//  NUM_REQ  4    number of requesters (>=2)
//  WIDTH    256  coordinate width; points packed {x,y}, 2*WIDTH bits
//  TIMEOUT  4096 max RUN cycles before the error response
// PORTS
//  clk         in   1                  clock
//  Reset       in   1                  synchronous, active-high reset
//  req_valid   in   NUM_REQ            job request per requester
//  req_ready   out  NUM_REQ            one-hot accept (comb, IDLE only)
//  req_P       in   NUM_REQ*2*WIDTH    requester i operand P at [i*2W +: 2W]
//  req_Q       in   NUM_REQ*2*WIDTH    requester i operand Q, same packing
//  resp_valid  out  NUM_REQ            one-hot, one-cycle result strobe
//  resp_R      out  2*WIDTH            result {Rx,Ry}, valid with resp_valid
//  resp_err    out  1                  1 = timeout, resp_R undefined
//  busy        out  1                  state != IDLE
//  pa_Reset    out  1                  to point_add Reset (high = hold/clear)
//  pa_P        out  2*WIDTH            to point_add P (latched operand)
//  pa_Q        out  2*WIDTH            to point_add Q (latched operand)
//  pa_R        in   2*WIDTH            from point_add R
//  pa_Done     in   1                  from point_add Done
// BEHAVIOUR
//  Reset: state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 has top priority; owner=0; cnt=0;
//   pa_P/pa_Q/resp_R=0; resp_valid=0; resp_err=0; req_ready=0; pa_Reset=1.
//  FSM IDLE -> RUN -> RESP -> IDLE.
//  IDLE:
//   - pa_Reset=1.
//   - grant = first i with req_valid[i], searching rr_ptr+1, rr_ptr+2, ... mod NUM_REQ.
//   - req_ready[grant]=1 in the same cycle (comb); handshake completes at that edge.
//   - At the edge: latch pa_P/pa_Q from grant's slice; owner<=grant; rr_ptr<=grant; cnt<=0; ->RUN.
//   - No req_valid: stay in IDLE, req_ready=0.
//  RUN:
//   - pa_Reset=0; operands held stable; cnt increments each cycle.
//   - pa_Done=1: latch resp_R<=pa_R, resp_err<=0, ->RESP.
//   - Else cnt==TIMEOUT-1: resp_err<=1, ->RESP.
//   - Done and timeout in the same cycle: Done wins, err=0.
//  RESP (1 cycle):
//   - resp_valid[owner]=1; pa_Reset=1 (clears point_add Done); ->IDLE.
//   - No backpressure: the requester must take the result this cycle.
//   - resp_R/resp_err hold until the next RESP.
//  Latency: accept edge at cycle 0; RUN spans cycles 1..L when pa_Done rises in cycle L;
//   resp_valid in cycle L+1; next accept no earlier than cycle L+2.
//   pa_Reset is high for at least 1 cycle between jobs.
//  Arbitration:
//   - At most one accept per IDLE cycle; req_ready never asserts outside IDLE.
//   - Requesters not granted keep req_valid and their operands stable until accepted.
//   - A requester deasserting req_valid before acceptance withdraws; this is legal.
//   - Starvation-free: with all NUM_REQ requesting, each is served once every NUM_REQ jobs.
//  Reset mid-job (RUN or RESP): abort, no resp_valid, pa_Reset=1 next cycle, rr_ptr reinitialised.
//  pa_Done seen in IDLE or RESP is ignored.
//  cnt is $clog2(TIMEOUT) bits wide; it saturates, never wraps.
// TESTING
//  (bench uses a point_add stub with programmable latency L, plus one run with the real point_add)
//  1. Real point_add, req0 P={6,1} Q={8,1} -> one resp_valid=4'b0001, resp_R={23,36}, resp_err=0.
//  2. Stub L=5, req2 alone -> req_ready[2] in cycle 0, pa_Reset low in cycles 1-5, resp_valid[2] in cycle 6.
//  3. All 4 requesting continuously -> grant order 0,1,2,3,0,1; each resp_valid matches its owner's stub result.
//  4. Stub never raises Done, TIMEOUT=16 -> resp_err=1 with resp_valid in cycle 17; the next job then proceeds normally.
//  5. Reset asserted in RUN cycle 3 -> no resp_valid; after release req0 is granted first.
//  6. Stub Done in the same cycle cnt==TIMEOUT-1 -> resp_err=0, resp_R=stub R.

Source files
------------

// File: rtl/point_add_sched.sv
// Round-robin scheduler sharing one point_add unit among NUM_REQ requesters.
// One job in flight at a time; a watchdog turns a missing Done into an error response.
module point_add_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 256,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*2*WIDTH-1:0] req_P,
  input  logic [NUM_REQ*2*WIDTH-1:0] req_Q,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [2*WIDTH-1:0]         resp_R,
  output logic                       resp_err,
  output logic                       busy,
  output logic                       pa_Reset,
  output logic [2*WIDTH-1:0]         pa_P,
  output logic [2*WIDTH-1:0]         pa_Q,
  input  logic [2*WIDTH-1:0]         pa_R,
  input  logic                       pa_Done
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StResp} state_e;

  state_e             state_q;
  logic [IdxW-1:0]    rr_q;
  logic [IdxW-1:0]    owner_q;
  logic [CntW-1:0]    cnt_q;
  logic [PW-1:0]      pa_p_q;
  logic [PW-1:0]      pa_q_q;
  logic [PW-1:0]      resp_r_q;
  logic               resp_err_q;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic               pa_reset_q;

  logic               grant_vld;
  logic [IdxW-1:0]    grant_idx;
  logic [NUM_REQ-1:0] owner_oh;

  // Search starts just after the last grant, so the previous winner ranks last.
  always_comb begin
    int unsigned idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(rr_q) + k) % NUM_REQ;
      if (!grant_vld && req_valid[IdxW'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = IdxW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && grant_vld && !Reset) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q      <= StIdle;
      rr_q         <= IdxW'(NUM_REQ - 1);
      owner_q      <= '0;
      cnt_q        <= '0;
      pa_p_q       <= '0;
      pa_q_q       <= '0;
      resp_r_q     <= '0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= '0;
      pa_reset_q   <= 1'b1;
    end else begin
      resp_valid_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (grant_vld) begin
            pa_p_q     <= req_P[grant_idx*PW +: PW];
            pa_q_q     <= req_Q[grant_idx*PW +: PW];
            owner_q    <= grant_idx;
            rr_q       <= grant_idx;
            cnt_q      <= '0;
            pa_reset_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          // Done has priority over the watchdog when both land in the same cycle.
          if (pa_Done) begin
            resp_r_q     <= pa_R;
            resp_err_q   <= 1'b0;
            resp_valid_q <= owner_oh;
            pa_reset_q   <= 1'b1;
            state_q      <= StResp;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            resp_err_q   <= 1'b1;
            resp_valid_q <= owner_oh;
            pa_reset_q   <= 1'b1;
            state_q      <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q    <= StIdle;
          pa_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_R     = resp_r_q;
  assign resp_err   = resp_err_q;
  assign busy       = (state_q != StIdle);
  assign pa_Reset   = pa_reset_q;
  assign pa_P       = pa_p_q;
  assign pa_Q       = pa_q_q;

endmodule

// File: tb/tb_point_add_sched.sv
// Bench for point_add_sched: point_add stub with programmable latency, cycle-level
// reference model of grant/latency/response behaviour, directed vectors and random traffic.
module tb_point_add_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned T  = 16;

  logic            clk = 1'b0;
  logic            Reset = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*PW-1:0] req_P;
  logic [N*PW-1:0] req_Q;
  logic [N-1:0]    resp_valid;
  logic [PW-1:0]   resp_R;
  logic            resp_err;
  logic            busy;
  logic            pa_Reset;
  logic [PW-1:0]   pa_P;
  logic [PW-1:0]   pa_Q;
  logic [PW-1:0]   pa_R;
  logic            pa_Done;

  logic [PW-1:0] p_arr [N];
  logic [PW-1:0] q_arr [N];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int stub_lat = 3;
  int stub_cnt = 0;
  bit rand_mode = 0;
  bit keep_mode = 0;
  int grant_log[$];

  // Reference model state
  int            m_last, m_acc, m_lat, m_resp, m_free, m_owner;
  logic          m_active = 1'b0;
  logic          m_err;
  logic [PW-1:0] m_p, m_q, m_r;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_P = '0;
    req_Q = '0;
    for (int i = 0; i < N; i++) begin
      req_P[i*PW +: PW] = p_arr[i];
      req_Q[i*PW +: PW] = q_arr[i];
    end
  end

  // Known-answer entry for {6,1}+{8,1}; any other operands get a cheap mixing function.
  function automatic logic [PW-1:0] stub_fn(input logic [PW-1:0] p, input logic [PW-1:0] q);
    if (p == 16'h0601 && q == 16'h0801) return 16'h1724;
    return {p[15:8] + q[15:8], p[7:0] ^ q[7:0]};
  endfunction

  always @(posedge clk) begin
    if (pa_Reset) stub_cnt <= 0;
    else          stub_cnt <= stub_cnt + 1;
  end

  always_comb begin
    pa_Done = !pa_Reset && (stub_lat != 0) && (stub_cnt == stub_lat - 1);
    pa_R    = stub_fn(pa_P, pa_Q);
  end

  point_add_sched #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(T)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_P      (req_P),
    .req_Q      (req_Q),
    .resp_valid (resp_valid),
    .resp_R     (resp_R),
    .resp_err   (resp_err),
    .busy       (busy),
    .pa_Reset   (pa_Reset),
    .pa_P       (pa_P),
    .pa_Q       (pa_Q),
    .pa_R       (pa_R),
    .pa_Done    (pa_Done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Model: a job accepted in cycle c with latency L (timeout if Done never comes by T)
  // runs in cycles c+1..c+lat, responds in c+lat+1, and the next accept is from c+lat+2.
  task automatic monitor();
    int g;
    logic [N-1:0] exp_rdy, exp_rv;
    logic in_run;
    forever begin
      @(negedge clk);
      if (Reset) begin
        m_last   = N - 1;
        m_active = 1'b0;
        m_resp   = -1;
        m_free   = cyc + 1;
        continue;
      end
      g = -1;
      exp_rdy = '0;
      if (cyc >= m_free) begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_last + k) % N;
          if (g < 0 && req_valid[i]) g = i;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      in_run = m_active && cyc > m_acc && cyc <= m_acc + m_lat;
      exp_rv = '0;
      if (m_active && cyc == m_resp) exp_rv[m_owner] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("pa_Reset", pa_Reset, !in_run);
      chk("busy", busy, m_active && cyc > m_acc && cyc <= m_resp);
      chk("resp_valid", resp_valid, exp_rv);
      if (in_run) begin
        chk("pa_P", pa_P, m_p);
        chk("pa_Q", pa_Q, m_q);
      end
      if (m_active && cyc == m_resp) begin
        chk("resp_err", resp_err, m_err);
        if (!m_err) chk("resp_R", resp_R, m_r);
        m_active = 1'b0;
      end
      if (g >= 0) begin
        m_last   = g;
        m_owner  = g;
        m_acc    = cyc;
        m_err    = (stub_lat == 0 || stub_lat > T);
        m_lat    = m_err ? T : stub_lat;
        m_p      = p_arr[g];
        m_q      = q_arr[g];
        m_r      = stub_fn(m_p, m_q);
        m_resp   = cyc + m_lat + 1;
        m_free   = m_resp + 1;
        m_active = 1'b1;
        grant_log.push_back(g);
      end
    end
  endtask

  // Requester behaviour: drop (or refresh, in keep_mode) a request once it is granted.
  task automatic driver();
    int pos = 0;
    int g;
    forever begin
      @(posedge clk);
      #1;
      while (pos < grant_log.size()) begin
        g = grant_log[pos];
        pos++;
        if (keep_mode) begin
          p_arr[g] = PW'($urandom);
          q_arr[g] = PW'($urandom);
        end else begin
          req_valid[g] = 1'b0;
        end
      end
      if (rand_mode) begin
        for (int i = 0; i < N; i++) begin
          if (!req_valid[i]) begin
            if ($urandom_range(0, 3) == 0) begin
              p_arr[i] = PW'($urandom);
              q_arr[i] = PW'($urandom);
              req_valid[i] = 1'b1;
            end
          end else if ($urandom_range(0, 15) == 0) begin
            req_valid[i] = 1'b0;
          end
        end
        if (!busy) stub_lat = $urandom_range(0, 18);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    Reset = 1'b1;
    @(posedge clk); #2;
    Reset = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("drain_idle", busy, 1'b0);
  endtask

  task automatic wait_grants(input int target, input string name);
    int k;
    for (k = 0; k < 200 && grant_log.size() < target; k++) @(negedge clk);
    chk(name, grant_log.size() >= target, 1'b1);
  endtask

  typedef struct {
    int            idx;
    int            lat;
    logic [PW-1:0] p;
    logic [PW-1:0] q;
    logic [PW-1:0] r;
    logic          err;
    int            rc;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t vecs[5];
    int   exp_order[6];
    int   n0;
    logic [N-1:0] oh;

    vecs[0] = '{0, 3,  16'h0601, 16'h0801, 16'h1724, 1'b0, 4};
    vecs[1] = '{2, 5,  16'h1020, 16'h0305, 16'h1325, 1'b0, 6};
    vecs[2] = '{1, 0,  16'hAAAA, 16'h5555, 16'h0000, 1'b1, 17};
    vecs[3] = '{3, 16, 16'h0102, 16'h0304, 16'h0406, 1'b0, 17};
    vecs[4] = '{1, 1,  16'hF00F, 16'h1001, 16'h000E, 1'b0, 2};
    exp_order = '{0, 1, 2, 3, 0, 1};

    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      p_arr[i] = '0;
      q_arr[i] = '0;
    end
    fork
      monitor();
      driver();
    join_none

    repeat (2) @(posedge clk);
    #2 Reset = 1'b0;
    @(negedge clk);
    chk("reset_resp_R", resp_R, '0);
    chk("reset_resp_err", resp_err, 1'b0);
    chk("reset_pa_P", pa_P, '0);
    chk("reset_pa_Q", pa_Q, '0);
    chk("reset_pa_Reset", pa_Reset, 1'b1);
    chk("reset_busy", busy, 1'b0);

    // Directed single-requester jobs: known answer, latency, timeout, Done at the deadline.
    for (int v = 0; v < 5; v++) begin
      int acc, rc;
      @(posedge clk); #2;
      stub_lat = vecs[v].lat;
      p_arr[vecs[v].idx] = vecs[v].p;
      q_arr[vecs[v].idx] = vecs[v].q;
      req_valid[vecs[v].idx] = 1'b1;
      acc = -1;
      for (int k = 0; k < 20 && acc < 0; k++) begin
        @(negedge clk);
        if (req_ready[vecs[v].idx]) acc = cyc;
      end
      chk("vec_accept", acc >= 0, 1'b1);
      rc = -1;
      oh = '0;
      oh[vecs[v].idx] = 1'b1;
      for (int k = 0; k < 40 && rc < 0 && acc >= 0; k++) begin
        @(negedge clk);
        if (resp_valid != '0) begin
          rc = cyc - acc;
          chk("vec_resp_owner", resp_valid, oh);
          chk("vec_resp_err", resp_err, vecs[v].err);
          if (!vecs[v].err) chk("vec_resp_R", resp_R, vecs[v].r);
        end
      end
      chk("vec_latency", rc, vecs[v].rc);
      @(negedge clk);
    end

    // All requesters busy: rotation from requester 0 after reset.
    do_reset();
    keep_mode = 1'b1;
    stub_lat  = 2;
    @(posedge clk); #2;
    for (int i = 0; i < N; i++) begin
      p_arr[i] = PW'($urandom);
      q_arr[i] = PW'($urandom);
    end
    n0 = grant_log.size();
    req_valid = '1;
    wait_grants(n0 + 6, "rr_grants_seen");
    for (int k = 0; k < 6; k++) begin
      if (grant_log.size() > n0 + k) chk("rr_order", grant_log[n0+k], exp_order[k]);
    end
    @(posedge clk); #2;
    keep_mode = 1'b0;
    req_valid = '0;
    drain();

    // Reset during RUN cycle 3 aborts the job; requester 0 wins afterwards.
    do_reset();
    @(posedge clk); #2;
    stub_lat = 10;
    p_arr[1] = 16'h1111;
    q_arr[1] = 16'h2222;
    req_valid[1] = 1'b1;
    n0 = grant_log.size();
    wait_grants(n0 + 1, "abort_job_granted");
    repeat (3) @(posedge clk);
    #2;
    Reset = 1'b1;
    p_arr[0] = 16'h0601;
    q_arr[0] = 16'h0801;
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    @(posedge clk); #2;
    Reset = 1'b0;
    n0 = grant_log.size();
    wait_grants(n0 + 1, "post_reset_grant_seen");
    if (grant_log.size() > n0) chk("post_reset_grant", grant_log[n0], 0);
    @(posedge clk); #2;
    req_valid = '0;
    drain();

    // Random traffic with withdrawals and random latencies, including timeouts.
    rand_mode = 1'b1;
    repeat (600) @(posedge clk);
    #2;
    rand_mode = 1'b0;
    req_valid = '0;
    drain();
    chk("random_jobs_ran", grant_log.size() > 20, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
